// File: rtl/algorithm_range_pkg.sv
`default_nettype none
// ============================================================================
// Module   : algorithm_range_pkg
// Brief    : Shared word width, terminator and FSM encoding for the range
//            source and the summing reducer.
// Revision : 1.0
// ============================================================================
package algorithm_range_pkg;

    localparam int INT_N = 16;

    // End-of-stream marker; the reducer treats it as "list exhausted".
    localparam logic [INT_N-1:0] c_TERM = {INT_N{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : algorithm_range_pkg
`default_nettype wire

// File: rtl/algorithm_range.sv
`default_nettype none
// ============================================================================
// Module   : algorithm_range
// Brief    : Demand-driven source emitting lo..hi-1 then one terminator, one
//            word per consumer request.
// Revision : 1.0
// ============================================================================
module algorithm_range
    import algorithm_range_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [INT_N-1:0] lo_in,
    input  logic [INT_N-1:0] hi_in,
    input  logic             elem_req,
    output logic             elem_valid,
    output logic [INT_N-1:0] elem_data,
    output logic             busy
);

    state_t           r_state;
    logic [INT_N-1:0] r_cur;
    logic [INT_N-1:0] r_hi;
    logic             r_valid;
    logic [INT_N-1:0] r_data;

    state_t           w_state_nxt;
    logic [INT_N-1:0] w_cur_nxt;
    logic [INT_N-1:0] w_hi_nxt;
    logic             w_valid_nxt;
    logic [INT_N-1:0] w_data_nxt;
    logic             w_has_elem;

    // The all-ones word can never be an element, so the count stops short of it.
    assign w_has_elem = (r_cur < r_hi) && (r_cur != c_TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_hi    <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_hi    <= w_hi_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_hi_nxt    = r_hi;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;

        case (r_state)
            ST_IDLE: begin
                // A request coinciding with start is dropped.
                if (start) begin
                    w_cur_nxt   = lo_in;
                    w_hi_nxt    = hi_in;
                    w_state_nxt = ST_RUN;
                end else if (elem_req) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = c_TERM;
                end
            end
            ST_RUN: begin
                if (elem_req) begin
                    w_valid_nxt = 1'b1;
                    if (w_has_elem) begin
                        w_data_nxt = r_cur;
                        w_cur_nxt  = r_cur + 1'b1;
                    end else begin
                        w_data_nxt  = c_TERM;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign elem_valid = r_valid;
    assign elem_data  = r_data;
    assign busy       = (r_state == ST_RUN);

endmodule : algorithm_range
`default_nettype wire

// File: doc/algorithm_range.md
# algorithm_range

Demand-driven integer stream source sitting directly upstream of the summing reducer. On a start pulse it captures a half-open range [lo, hi) and then, one element per consumer request, emits lo, lo+1, …, hi-1 followed by a single end-of-stream terminator. The terminator is the all-ones word, which the downstream reducer treats as "list exhausted". The output is the list operand the reducer folds with its accumulator.

## Interface
- INT_N, 16, data word width in bits; terminator is {INT_N{1'b1}}
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; captures lo_in/hi_in when idle
- lo_in  in  INT_N  first element (unsigned)
- hi_in  in  INT_N  exclusive bound (unsigned)
- elem_req  in  1  consumer requests next element (one-cycle pulse per element)
- elem_valid  out  1  registered; high for exactly one cycle per accepted request
- elem_data  out  INT_N  registered; element value or terminator, meaningful only when elem_valid
- busy  out  1  high while a range is active (state RUN)

## Operation
- States: IDLE, RUN. Registers: cur (INT_N), hi (INT_N), elem_valid, elem_data.
- IDLE + start: cur <= lo_in, hi <= hi_in, state <= RUN. elem_req in the same cycle is dropped (no response).
- IDLE + elem_req (no start): respond with terminator (empty stream); state stays IDLE.
- RUN + elem_req:
  - If cur < hi (unsigned) and cur != all-ones: elem_data <= cur, elem_valid <= 1, cur <= cur + 1 (INT_N-bit, no carry out).
  - Otherwise: elem_data <= all-ones, elem_valid <= 1, state <= IDLE.
- Any value equal to the all-ones word is never emitted as an element. A range reaching it terminates there, so wrap-around cannot occur.
- lo_in >= hi_in gives an empty stream: the first request returns the terminator.
- RUN + start: start is ignored, and lo_in/hi_in are not recaptured.
- No request: elem_valid <= 0, and elem_data holds its last value.
- Exactly one terminator is emitted per range. Requests after it are served by the IDLE rule (further terminators).

## Timing
- Reset values: state IDLE, busy 0, elem_valid 0, elem_data 0, cur 0, hi 0.
- rst asserted mid-range aborts immediately, with no terminator emitted. The first cycle after deassertion behaves as IDLE.
- start to busy: 1 cycle.
- elem_req to elem_valid/elem_data: 1 cycle. Back-to-back requests on consecutive cycles are sustained at one element per cycle.
- busy falls in the same cycle elem_valid presents the terminator.
- A start in the cycle after the terminator response is accepted (IDLE).

## Structure
- Shared package holds INT_N and the terminator constant, defined as all-ones of INT_N. The reducer uses the same package.
- Single flat module: a 2-state FSM plus the cur/hi registers and the output register. No sub-module is natural.

## Test plan
- Reset, then start lo=3 hi=6, then 4 requests on consecutive cycles -> elem_data 3, 4, 5, 0xFFFF. busy falls with the 0xFFFF response.
- start lo=5 hi=5, then 1 request -> single 0xFFFF response. busy high for exactly 1 cycle.
- start lo=0xFFFD hi=0xFFFF, then 3 requests -> 0xFFFD, 0xFFFE, 0xFFFF(term). No wrap to 0.
- start lo=0 hi=100, 10 requests, then start lo=7 hi=9 while busy, then 3 requests -> 10, 11, 12 (second start ignored).
- start lo=0 hi=100, 5 requests, rst pulse, then request -> elem_valid 0 during reset, then one 0xFFFF (IDLE rule). busy 0.
- Requests gapped by 3 idle cycles with lo=1 hi=3 -> 1, 2, term, each exactly 1 cycle after its request, with elem_valid low between responses.
